// File: rtl/seg_scan_ctrl_if.sv
// Bus between the scan controller and its neighbours: the display word,
// the load strobe and blanking control go in; the per-digit drive for the
// seven_segment decoder and the frame pulse come out.
interface seg_scan_ctrl_if;
  logic        load;
  logic [31:0] value_in;
  logic        blank_lz;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_done;

  // Side that supplies words and reads back the digit drive
  modport master (
    output load, value_in, blank_lz,
    input  num, sel, blank, frame_done
  );

  // The scan controller itself
  modport slave (
    input  load, value_in, blank_lz,
    output num, sel, blank, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit hex display scanner. A prescaler steps the digit
// index once every REFRESH_DIV cycles. New words wait in a pending buffer
// and are copied to the display register only when the scan wraps, so a
// frame never mixes digits from two different words.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    bus
);

  localparam int          CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]  SEL_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_q, pend_d;
  logic             pendValid_q, pendValid_d;
  logic [3:0]       num_q, num_d;
  logic             blank_q, blank_d;
  logic             frameDone_q, frameDone_d;
  logic             step;
  logic             boundary;

  // Next-state logic: prescaler, digit index, double buffer and the digit
  // outputs, which are derived from the next sel/display so that digit 0
  // of a new frame already shows the new word.
  always_comb begin
    step        = (cnt_q == CNT_LAST);
    boundary    = step && (sel_q == SEL_LAST);
    cnt_d       = step ? '0 : cnt_q + CNT_W'(1);
    sel_d       = sel_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;

    if (step) begin
      sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    end

    if (bus.load) begin
      pend_d = bus.value_in;
    end

    if (boundary) begin
      if (bus.load) begin
        disp_d = bus.value_in;
      end else if (pendValid_q) begin
        disp_d = pend_q;
      end
      pendValid_d = 1'b0;
    end else if (bus.load) begin
      pendValid_d = 1'b1;
    end

    num_d = disp_d[{sel_d, 2'b00} +: 4];

    blank_d = bus.blank_lz && (sel_d != 3'd0);
    for (int i = 0; i < 8; i++) begin
      if ((i < NUM_DIGITS) && (i >= int'(sel_d)) && (disp_d[4*i +: 4] != 4'd0)) begin
        blank_d = 1'b0;
      end
    end

    frameDone_d = boundary;
  end

  // State and output registers with synchronous reset; reset also drops
  // any load presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      disp_q      <= 32'd0;
      pend_q      <= 32'd0;
      pendValid_q <= 1'b0;
      num_q       <= 4'd0;
      blank_q     <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      num_q       <= num_d;
      blank_q     <= blank_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.num        = num_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with REFRESH_DIV=4, NUM_DIGITS=8. A frame-level
// reference model predicts every cycle's outputs into a queue which is
// drained after each edge, alongside fixed-value checks for the scan
// timing, the buffering corner cases and a table of blanking vectors.
module tb_seg_scan_ctrl;

  localparam int RD = 4;
  localparam int ND = 8;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] num;
    logic       blank;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    logic        lz;
    logic [2:0]  sel;
    logic [3:0]  num;
    logic        blank;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exp_t expQ[$];
  vec_t vecs[14];

  int          mCnt;
  int          mSel;
  logic [31:0] mDisp;
  logic [31:0] mPend;
  logic        mPendV;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .NUM_DIGITS  (ND)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Blank predicted from the highest nonzero digit: a slot is dark when
  // it lies strictly above that digit (and is not digit 0).
  function automatic logic modelBlank(input logic [31:0] word, input int sel, input logic lz);
    int h;
    h = -1;
    for (int i = 0; i < ND; i++) begin
      if (((word >> (4 * i)) & 32'hF) != 0) h = i;
    end
    return lz && (sel != 0) && (sel > h);
  endfunction

  task automatic runCycle();
    exp_t e;
    logic bnd;
    if (rst) begin
      mCnt = 0; mSel = 0; mDisp = 0; mPend = 0; mPendV = 1'b0;
      e.sel = 3'd0; e.num = 4'd0; e.blank = 1'b0; e.fd = 1'b0;
    end else begin
      bnd = (mCnt == RD - 1) && (mSel == ND - 1);
      if (mCnt == RD - 1) begin
        mCnt = 0;
        mSel = (mSel + 1) % ND;
      end else begin
        mCnt++;
      end
      if (bnd) begin
        if (bus.load) mDisp = bus.value_in;
        else if (mPendV) mDisp = mPend;
        mPendV = 1'b0;
      end else if (bus.load) begin
        mPend  = bus.value_in;
        mPendV = 1'b1;
      end
      e.sel   = 3'(mSel);
      e.num   = 4'((mDisp >> (4 * mSel)) & 32'hF);
      e.blank = modelBlank(mDisp, mSel, bus.blank_lz);
      e.fd    = bnd;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("sb_sel", int'(bus.sel), int'(e.sel));
    checkOutput("sb_num", int'(bus.num), int'(e.num));
    checkOutput("sb_blank", int'(bus.blank), int'(e.blank));
    checkOutput("sb_frame_done", int'(bus.frame_done), int'(e.fd));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    bus.load     = 1'b1;
    bus.value_in = word;
    runCycle();
    bus.load     = 1'b0;
  endtask

  task automatic waitFrameDone(input string name);
    int n;
    n = 0;
    runCycle();
    while (bus.frame_done !== 1'b1 && n < 4 * ND * RD) begin
      runCycle();
      n++;
    end
    checkOutput({name, "_frame_done_seen"}, int'(bus.frame_done), 1);
  endtask

  task automatic waitSel(input string name, input logic [2:0] target);
    int n;
    n = 0;
    while (bus.sel !== target && n < 2 * ND * RD) begin
      runCycle();
      n++;
    end
    checkOutput({name, "_sel_reached"}, int'(bus.sel), int'(target));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = 32'd0;
    bus.blank_lz = 1'b0;
    mCnt = 0; mSel = 0; mDisp = 0; mPend = 0; mPendV = 1'b0;

    vecs[0]  = '{32'h00000120, 1'b1, 3'd7, 4'h0, 1'b1};
    vecs[1]  = '{32'h00000120, 1'b1, 3'd5, 4'h0, 1'b1};
    vecs[2]  = '{32'h00000120, 1'b1, 3'd3, 4'h0, 1'b1};
    vecs[3]  = '{32'h00000120, 1'b1, 3'd2, 4'h1, 1'b0};
    vecs[4]  = '{32'h00000120, 1'b1, 3'd1, 4'h2, 1'b0};
    vecs[5]  = '{32'h00000120, 1'b1, 3'd0, 4'h0, 1'b0};
    vecs[6]  = '{32'h00000000, 1'b1, 3'd7, 4'h0, 1'b1};
    vecs[7]  = '{32'h00000000, 1'b1, 3'd1, 4'h0, 1'b1};
    vecs[8]  = '{32'h00000000, 1'b1, 3'd0, 4'h0, 1'b0};
    vecs[9]  = '{32'h00000000, 1'b0, 3'd7, 4'h0, 1'b0};
    vecs[10] = '{32'h00000000, 1'b0, 3'd1, 4'h0, 1'b0};
    vecs[11] = '{32'h50000000, 1'b1, 3'd6, 4'h0, 1'b0};
    vecs[12] = '{32'h00F00000, 1'b1, 3'd6, 4'h0, 1'b1};
    vecs[13] = '{32'h00F00000, 1'b1, 3'd5, 4'hF, 1'b0};

    // Reset and first frame timing, with a load mid-frame
    runCycles(2);
    checkOutput("t1_reset_sel", int'(bus.sel), 0);
    checkOutput("t1_reset_num", int'(bus.num), 0);
    rst = 1'b0;
    runCycles(4);
    checkOutput("t1_sel_edge4", int'(bus.sel), 1);
    applyStimulus(32'h89ABCDEF);
    runCycles(23);
    checkOutput("t1_sel_edge28", int'(bus.sel), 7);
    checkOutput("t2_num_old_frame", int'(bus.num), 0);
    runCycles(4);
    checkOutput("t1_sel_edge32", int'(bus.sel), 0);
    checkOutput("t1_fd_edge32", int'(bus.frame_done), 1);
    checkOutput("t2_num_sel0", int'(bus.num), 'hF);
    runCycle();
    checkOutput("t1_fd_edge33", int'(bus.frame_done), 0);
    runCycles(11);
    checkOutput("t2_sel3", int'(bus.sel), 3);
    checkOutput("t2_num_sel3", int'(bus.num), 'hC);
    runCycles(16);
    checkOutput("t2_num_sel7", int'(bus.num), 'h8);

    // Table of blanking vectors: load, wait for it to show, check one slot
    for (int v = 0; v < 14; v++) begin
      bus.blank_lz = vecs[v].lz;
      applyStimulus(vecs[v].word);
      waitFrameDone($sformatf("vec%0d", v));
      waitSel($sformatf("vec%0d", v), vecs[v].sel);
      checkOutput($sformatf("vec%0d_num", v), int'(bus.num), int'(vecs[v].num));
      checkOutput($sformatf("vec%0d_blank", v), int'(bus.blank), int'(vecs[v].blank));
    end
    bus.blank_lz = 1'b0;

    // Last of two loads in one frame wins
    waitFrameDone("t5_align");
    applyStimulus(32'h11111111);
    applyStimulus(32'h22222222);
    waitFrameDone("t5");
    checkOutput("t5_num_lastwins", int'(bus.num), 2);
    runCycles(RD * 3);
    checkOutput("t5_num_sel3", int'(bus.num), 2);

    // Load coincident with the boundary edge shows immediately
    while (!(mSel == ND - 1 && mCnt == RD - 1)) runCycle();
    applyStimulus(32'h33333333);
    checkOutput("t5_coincident_sel", int'(bus.sel), 0);
    checkOutput("t5_coincident_num", int'(bus.num), 3);
    checkOutput("t5_coincident_fd", int'(bus.frame_done), 1);

    // Reset mid-frame discards the pending word
    applyStimulus(32'hAAAAAAAA);
    waitSel("t6", 3'd5);
    rst = 1'b1;
    runCycle();
    checkOutput("t6_rst_sel", int'(bus.sel), 0);
    checkOutput("t6_rst_num", int'(bus.num), 0);
    checkOutput("t6_rst_blank", int'(bus.blank), 0);
    checkOutput("t6_rst_fd", int'(bus.frame_done), 0);
    rst = 1'b0;
    waitFrameDone("t6");
    checkOutput("t6_num_after", int'(bus.num), 0);
    runCycles(RD * 4);
    checkOutput("t6_num_sel4", int'(bus.num), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
